// File: rtl/ifid_skid_if.sv
// IF/ID handshake bundle: fetch-side inputs, decode-side outputs, hazard controls.
// The master modport is the fetch/decode environment; the slave modport is the skid register.
interface ifid_skid_if #(
    parameter int PC_W    = 32,
    parameter int INSTR_W = 32,
    parameter int CNT_W   = 16
);
    logic               in_valid;
    logic               in_ready;
    logic [PC_W-1:0]    in_pc;
    logic [PC_W-1:0]    in_pcadd4;
    logic [INSTR_W-1:0] in_instr;
    logic               out_valid;
    logic               out_ready;
    logic               stall;
    logic               flush;
    logic [PC_W-1:0]    out_pc;
    logic [PC_W-1:0]    out_pcadd4;
    logic [INSTR_W-1:0] out_instr;
    logic [1:0]         out_status;
    logic [CNT_W-1:0]   stall_cnt;

    modport master (
        output in_valid, in_pc, in_pcadd4, in_instr, out_ready, stall, flush,
        input  in_ready, out_valid, out_pc, out_pcadd4, out_instr, out_status, stall_cnt
    );

    modport slave (
        input  in_valid, in_pc, in_pcadd4, in_instr, out_ready, stall, flush,
        output in_ready, out_valid, out_pc, out_pcadd4, out_instr, out_status, stall_cnt
    );
endinterface

// File: rtl/ifid_skid_reg.sv
// IF/ID pipeline register with a 2-entry skid buffer, stall hold, flush-to-NOP,
// per-entry status code and a saturating stall-cycle counter.
//
// state   | meaning
// --------+------------------------------------------------
// S_EMPTY | no entry; outputs show NOP bubble
// S_ONE   | main entry valid, skid empty, accepting input
// S_TWO   | main and skid valid, input blocked
module ifid_skid_reg #(
    parameter int                 PC_W      = 32,
    parameter int                 INSTR_W   = 32,
    parameter logic [INSTR_W-1:0] NOP_INSTR = 32'h00000013,
    parameter int                 CNT_W     = 16
) (
    input logic          clk,
    input logic          rst,
    ifid_skid_if.slave   bus
);
    typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;

    localparam logic [1:0] ST_NEW    = 2'd0;
    localparam logic [1:0] ST_BUBBLE = 2'd1;
    localparam logic [1:0] ST_HELD   = 2'd2;

    state_t             state;
    logic               in_ready_q;
    logic [1:0]         status_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [PC_W-1:0]    main_pc, main_pcadd4, skid_pc, skid_pcadd4;
    logic [INSTR_W-1:0] main_instr, skid_instr;
    logic               out_valid;
    logic               in_fire, out_fire;

    assign out_valid = (state != S_EMPTY);
    assign in_fire   = bus.in_valid & in_ready_q;
    assign out_fire  = out_valid & bus.out_ready & ~bus.stall;

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid;
    assign bus.out_pc     = main_pc;
    assign bus.out_pcadd4 = main_pcadd4;
    assign bus.out_instr  = main_instr;
    assign bus.out_status = status_q;
    assign bus.stall_cnt  = cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_EMPTY;
            in_ready_q  <= 1'b1;
            status_q    <= ST_BUBBLE;
            cnt_q       <= '0;
            main_pc     <= '0;
            main_pcadd4 <= '0;
            main_instr  <= NOP_INSTR;
            skid_pc     <= '0;
            skid_pcadd4 <= '0;
            skid_instr  <= NOP_INSTR;
        end else begin
            // Counter tracks the cycle just ending, so flush does not suppress it.
            if (out_valid && !out_fire && cnt_q != {CNT_W{1'b1}})
                cnt_q <= cnt_q + 1'b1;

            if (bus.flush) begin
                state       <= S_EMPTY;
                in_ready_q  <= 1'b1;
                status_q    <= ST_BUBBLE;
                main_pc     <= '0;
                main_pcadd4 <= '0;
                main_instr  <= NOP_INSTR;
            end else begin
                case (state)
                    S_EMPTY: begin
                        if (in_fire) begin
                            state       <= S_ONE;
                            status_q    <= ST_NEW;
                            main_pc     <= bus.in_pc;
                            main_pcadd4 <= bus.in_pcadd4;
                            main_instr  <= bus.in_instr;
                        end else begin
                            status_q    <= ST_BUBBLE;
                        end
                    end
                    S_ONE: begin
                        if (in_fire && out_fire) begin
                            status_q    <= ST_NEW;
                            main_pc     <= bus.in_pc;
                            main_pcadd4 <= bus.in_pcadd4;
                            main_instr  <= bus.in_instr;
                        end else if (out_fire) begin
                            state       <= S_EMPTY;
                            status_q    <= ST_BUBBLE;
                            main_pc     <= '0;
                            main_pcadd4 <= '0;
                            main_instr  <= NOP_INSTR;
                        end else if (in_fire) begin
                            state       <= S_TWO;
                            status_q    <= ST_HELD;
                            in_ready_q  <= 1'b0;
                            skid_pc     <= bus.in_pc;
                            skid_pcadd4 <= bus.in_pcadd4;
                            skid_instr  <= bus.in_instr;
                        end else begin
                            status_q    <= ST_HELD;
                        end
                    end
                    S_TWO: begin
                        if (out_fire) begin
                            state       <= S_ONE;
                            status_q    <= ST_NEW;
                            in_ready_q  <= 1'b1;
                            main_pc     <= skid_pc;
                            main_pcadd4 <= skid_pcadd4;
                            main_instr  <= skid_instr;
                        end else begin
                            status_q    <= ST_HELD;
                        end
                    end
                    default: begin
                        state       <= S_EMPTY;
                        in_ready_q  <= 1'b1;
                        status_q    <= ST_BUBBLE;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ifid_skid_reg.sv
// Scoreboard bench for ifid_skid_reg: accepted entries are queued and checked in order
// at consumption; directed scenarios check status, ready, flush, reset and counter saturation.
module tb_ifid_skid_reg;
    localparam int PC_W    = 32;
    localparam int INSTR_W = 32;
    localparam int CNT_W   = 4;
    localparam logic [31:0] NOP = 32'h00000013;

    typedef struct {
        logic [PC_W-1:0]    pc;
        logic [PC_W-1:0]    pcadd4;
        logic [INSTR_W-1:0] instr;
    } entry_t;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;
    entry_t sb_q[$];

    ifid_skid_if #(.PC_W(PC_W), .INSTR_W(INSTR_W), .CNT_W(CNT_W)) bus ();

    ifid_skid_reg #(.PC_W(PC_W), .INSTR_W(INSTR_W), .NOP_INSTR(NOP), .CNT_W(CNT_W)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor: inputs are stable at the falling edge, so fire decisions for the next edge are known.
    always @(negedge clk) begin
        if (rst) begin
            if (bus.flush) begin
                sb_q.delete();
            end else begin
                if (bus.out_valid && bus.out_ready && !bus.stall) begin
                    if (sb_q.size() == 0) begin
                        chk("sb_unexpected_out", {32'h0, bus.out_pc}, 64'hDEAD);
                    end else begin
                        entry_t e;
                        e = sb_q.pop_front();
                        chk("sb_pc",     bus.out_pc,     e.pc);
                        chk("sb_pcadd4", bus.out_pcadd4, e.pcadd4);
                        chk("sb_instr",  bus.out_instr,  e.instr);
                    end
                end
                if (bus.in_valid && bus.in_ready) begin
                    entry_t e;
                    e.pc = bus.in_pc; e.pcadd4 = bus.in_pcadd4; e.instr = bus.in_instr;
                    sb_q.push_back(e);
                end
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] instr);
        bus.in_valid  = v;
        bus.in_pc     = pc;
        bus.in_pcadd4 = pc + 32'd4;
        bus.in_instr  = instr;
    endtask

    task automatic check_bubble(input string tag);
        chk({tag, "_valid"},  bus.out_valid, 0);
        chk({tag, "_instr"},  bus.out_instr, NOP);
        chk({tag, "_pc"},     bus.out_pc, 0);
        chk({tag, "_status"}, bus.out_status, 1);
        chk({tag, "_ready"},  bus.in_ready, 1);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        drive(0, 0, 0);
        bus.out_ready = 0; bus.stall = 0; bus.flush = 0;
        sb_q.delete();
        cycle(); cycle();
        check_bubble("rst");
        chk("rst_cnt", bus.stall_cnt, 0);
        rst = 1'b1;
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        rst = 1'b0;
        drive(0, 0, 0);
        bus.out_ready = 0; bus.stall = 0; bus.flush = 0;

        // Basic pass-through with one-cycle latency
        do_reset();
        drive(1, 32'h100, 32'h00500093); bus.out_ready = 1;
        cycle();
        drive(0, 0, 0);
        chk("s1_valid", bus.out_valid, 1);
        chk("s1_pc", bus.out_pc, 32'h100);
        chk("s1_pcadd4", bus.out_pcadd4, 32'h104);
        chk("s1_instr", bus.out_instr, 32'h00500093);
        chk("s1_status", bus.out_status, 0);
        cycle();
        check_bubble("s1_drain");

        // Skid fill under backpressure, then in-order drain
        do_reset();
        drive(1, 32'h200, 32'hA200);
        cycle();
        chk("s2_ready_a", bus.in_ready, 1);
        chk("s2_status_a", bus.out_status, 0);
        drive(1, 32'h204, 32'hA204);
        cycle();
        chk("s2_ready_b", bus.in_ready, 0);
        chk("s2_status_b", bus.out_status, 2);
        chk("s2_pc_b", bus.out_pc, 32'h200);
        drive(1, 32'h208, 32'hA208);
        cycle();
        chk("s2_ready_c", bus.in_ready, 0);
        chk("s2_status_c", bus.out_status, 2);
        chk("s2_pc_c", bus.out_pc, 32'h200);
        bus.out_ready = 1;
        cycle();
        chk("s2_pc_d", bus.out_pc, 32'h204);
        chk("s2_status_d", bus.out_status, 0);
        chk("s2_ready_d", bus.in_ready, 1);
        cycle();
        drive(0, 0, 0);
        chk("s2_pc_e", bus.out_pc, 32'h208);
        chk("s2_status_e", bus.out_status, 0);
        cycle();
        check_bubble("s2_end");
        chk("s2_qempty", sb_q.size(), 0);
        chk("s2_cnt", bus.stall_cnt, 2);

        // Stall holds the entry even with out_ready high
        do_reset();
        bus.stall = 1; bus.out_ready = 1;
        drive(1, 32'h400, 32'hA400);
        cycle();
        drive(0, 0, 0);
        chk("s3_status_load", bus.out_status, 0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("s3_pc_hold", bus.out_pc, 32'h400);
            chk("s3_status_hold", bus.out_status, 2);
        end
        chk("s3_cnt", bus.stall_cnt, 3);
        bus.stall = 0;
        cycle();
        check_bubble("s3_release");
        chk("s3_cnt_after", bus.stall_cnt, 3);
        chk("s3_qempty", sb_q.size(), 0);

        // Flush from TWO discards both entries and the simultaneous input
        do_reset();
        drive(1, 32'h500, 32'hA500);
        cycle();
        drive(1, 32'h504, 32'hA504);
        cycle();
        chk("s4_ready_two", bus.in_ready, 0);
        bus.flush = 1; bus.stall = 1;
        drive(1, 32'h300, 32'hA300);
        cycle();
        bus.flush = 0; bus.stall = 0;
        drive(0, 0, 0);
        check_bubble("s4_flush");
        chk("s4_cnt", bus.stall_cnt, 2);
        bus.out_ready = 1;
        repeat (3) cycle();
        chk("s4_no_300", bus.out_valid, 0);
        chk("s4_cnt_keep", bus.stall_cnt, 2);

        // Asynchronous reset mid-cycle while in TWO
        do_reset();
        drive(1, 32'h600, 32'hA600);
        cycle();
        drive(1, 32'h604, 32'hA604);
        cycle();
        chk("s5_ready_two", bus.in_ready, 0);
        chk("s5_cnt_pre", bus.stall_cnt, 1);
        #3;
        rst = 1'b0;
        drive(0, 0, 0);
        sb_q.delete();
        #1;
        check_bubble("s5_async");
        chk("s5_cnt", bus.stall_cnt, 0);
        cycle();
        rst = 1'b1;
        bus.out_ready = 1;
        drive(1, 32'h700, 32'hA700);
        cycle();
        drive(0, 0, 0);
        chk("s5_reload_pc", bus.out_pc, 32'h700);
        chk("s5_reload_status", bus.out_status, 0);
        cycle();
        chk("s5_qempty", sb_q.size(), 0);

        // Counter saturation with CNT_W=4
        do_reset();
        drive(1, 32'h800, 32'hA800);
        cycle();
        drive(0, 0, 0);
        repeat (20) cycle();
        chk("s6_cnt_sat", bus.stall_cnt, 15);
        chk("s6_pc_hold", bus.out_pc, 32'h800);
        bus.out_ready = 1;
        cycle();
        check_bubble("s6_drain");
        chk("s6_cnt_keep", bus.stall_cnt, 15);
        chk("s6_qempty", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
